reaction_display: RTL
=====================

Name: reaction_display

Overview:
- Downstream consumer of the reaction-game core FSM outputs: the 19-bit measured time (µs), the 3-bit display-state code and a "show best" switch.
- Tracks the best (lowest) score since reset.
- Converts the selected score to 6 BCD digits with a sequential double-dabble engine.
- Drives a 6-digit time-multiplexed common-anode 7-segment display: leading-zero blanking, dash patterns for the no-score and early-click cases.

Parameters:
- SCAN_W, 16, width of the digit-scan prescaler; the digit advances every 2^SCAN_W clocks.
- NO_SCORE, 19'h7FFFF, sentinel value meaning "no valid score".

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_measured  input  19  last measured reaction time in µs; updated on the same clock edge that i_dst enters 3'b110
- i_dst  input  3  core display code: 000 idle, 001 wait, 010 lit, 011 early, 110 finish
- i_show_best  input  1  level, already synchronised; 1 selects the best score for display, 0 selects the last score
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- o_an  output  6  digit anodes, active-low one-hot, bit 0 = least significant digit
- o_best  output  19  best score so far
- o_busy  output  1  high while a conversion is running

Behaviour:
- Reset:
  - o_best = NO_SCORE; last = NO_SCORE; BCD display digits all 0; state IDLE; o_busy = 0.
  - Scan prescaler and digit index = 0; o_an = 6'b111110; o_seg = 7'b1111111.
  - Previous-dst register = 000; previous-show-best register = i_show_best sampled value 0.
- Finish event:
  - Condition: i_dst == 110 and the previous-cycle dst != 110.
  - Same cycle: last <= i_measured; if i_measured < o_best then o_best <= i_measured (unsigned compare, registered next edge).
- Start conditions:
  - (a) a finish event, or (b) i_show_best differs from its registered previous value.
  - Source value: i_show_best ? best-after-update : last-after-update. The new i_measured is used directly on a finish cycle, so that update is not missed.
- Conversion FSM, IDLE -> CONV -> IDLE:
  - The start cycle loads shift reg = source, BCD accumulator = 0, bit counter = 0, o_busy = 1.
  - CONV runs 19 cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd, shift} shifts left by 1.
  - After the 19th shift: display digits <= accumulator, display-value register <= source, o_busy = 0.
  - Latency: digits valid 20 clocks after the start cycle.
- Start while CONV:
  - A finish event aborts and restarts immediately with the new source; the finish event wins over show-best.
  - A show-best toggle alone sets a pending flag; the conversion restarts the cycle after the current one completes. A pending flag alone is not lost.
- Scan:
  - Prescaler increments every clock. On wrap, the digit index goes 0→1→…→5→0.
  - o_an = ~(1 << index), registered.
  - o_seg is registered from the digit at the current index, so segment and anode change on the same edge.
- Digit patterns (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - dash=0111111, blank=1111111.
- Pattern priority, highest first:
  - i_dst == 011 → all digits dash.
  - Display-value register == NO_SCORE → all digits dash.
  - i_dst ∈ {001, 010} → all digits blank.
  - Otherwise show the BCD digits, with leading-zero blanking: digit k blank if k > 0 and digits k..5 are all zero; digit 0 is always shown.
- Range: 19 bits max 524287, so 6 digits always suffice; no overflow handling.
- Reset mid-conversion: abandons the conversion; display returns to the reset state (dashes once scanning, since value = NO_SCORE).

Test Plan:
- Conversion latency: reset, SCAN_W=2, pulse i_dst 000→110 with i_measured=123456 → o_busy high 20 clocks, then scan shows digits 6,5,4,3,2,1 on o_an bits 0..5; o_best=123456.
- Leading-zero blanking: finish with i_measured=42 → an0 seg 0100100, an1 seg 0011001, an2–an5 seg 1111111; i_measured=0 → only an0 shows 1000000.
- Best tracking: finish sequence 300, 250, 400 → o_best 300, 250, 250; toggle i_show_best=1 → display 250 after 20 clocks; back to 0 → display 400.
- Early and no-score dashes: i_dst=011 → all digits 0111111; after reset with i_dst=000 → all digits dash (NO_SCORE).
- Priority and pending: toggle i_show_best mid-CONV → second conversion starts right after the first completes. A finish event mid-CONV (value 777) restarts immediately → final display 777 exactly 20 clocks after that finish.
- Reset mid-conversion: assert i_rst at CONV cycle 10 → o_busy=0, o_best=7FFFF, display shows dashes; a subsequent finish with 99 converts normally.

Source files
------------

// File: rtl/reaction_display.sv
// Reaction-game display back end: best-score tracking, sequential binary-to-BCD
// conversion and a multiplexed 6-digit common-anode 7-segment driver.
module reaction_display #(
    parameter int unsigned SCAN_W   = 16,
    parameter logic [18:0] NO_SCORE = 19'h7FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [18:0] i_measured,
    input  logic [2:0]  i_dst,
    input  logic        i_show_best,
    output logic [6:0]  o_seg,
    output logic [5:0]  o_an,
    output logic [18:0] o_best,
    output logic        o_busy
);

    localparam int unsigned VAL_W = 19;
    localparam int unsigned DIG_N = 6;
    localparam int unsigned BCD_W = 4 * DIG_N;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned IDX_W = 3;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(VAL_W);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIG_N - 1);
    localparam logic [2:0]       DST_WAIT   = 3'b001;
    localparam logic [2:0]       DST_LIT    = 3'b010;
    localparam logic [2:0]       DST_EARLY  = 3'b011;
    localparam logic [2:0]       DST_FINISH = 3'b110;
    localparam logic [6:0]       SEG_DASH   = 7'b0111111;
    localparam logic [6:0]       SEG_BLANK  = 7'b1111111;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t              state_q, state_d;
    logic [VAL_W-1:0]    best_q, best_d;
    logic [VAL_W-1:0]    last_q, last_d;
    logic [VAL_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                pend_q, pend_d;
    logic [VAL_W-1:0]    src_q, src_d;
    logic [BCD_W-1:0]    digits_q, digits_d;
    logic [VAL_W-1:0]    dval_q, dval_d;
    logic [2:0]          prev_dst_q;
    logic                prev_sb_q;
    logic [SCAN_W-1:0]   presc_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [5:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIG_N-1:0]    blank_v;
    logic [3:0]          digit_sel;
    logic                fin_ev;
    logic                tog_ev;
    logic [VAL_W-1:0]    src_val;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // Score bookkeeping; the fresh measurement is forwarded so a finish cycle converts it directly.
    assign fin_ev  = (i_dst == DST_FINISH) && (prev_dst_q != DST_FINISH);
    assign tog_ev  = (i_show_best != prev_sb_q);
    assign best_d  = (fin_ev && (i_measured < best_q)) ? i_measured : best_q;
    assign last_d  = fin_ev ? i_measured : last_q;
    assign src_val = i_show_best ? best_d : last_d;

    // Double-dabble add-3 correction on every BCD nibble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < int'(DIG_N); k++) begin
            if (bcd_q[k*4 +: 4] >= 4'd5) begin
                bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: a finish event restarts at once, a show-best toggle waits its turn.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        pend_d   = pend_q;
        src_d    = src_q;
        digits_d = digits_q;
        dval_d   = dval_q;
        if (fin_ev || (state_q == S_IDLE && (tog_ev || pend_q))) begin
            state_d = S_CONV;
            shift_d = src_val;
            bcd_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            pend_d  = 1'b0;
            src_d   = src_val;
        end else if (state_q == S_CONV) begin
            if (tog_ev) begin
                pend_d = 1'b1;
            end
            if (cnt_q == LAST_CNT) begin
                digits_d = bcd_q;
                dval_d   = src_q;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end else begin
                bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[VAL_W-1]};
                shift_d = {shift_q[VAL_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Leading-zero blanking mask, scanned from the most significant digit down.
    always_comb begin : blank_calc
        logic nz;
        nz      = 1'b0;
        blank_v = '0;
        for (int k = int'(DIG_N) - 1; k >= 0; k--) begin
            nz         = nz | (digits_q[k*4 +: 4] != 4'd0);
            blank_v[k] = ~nz && (k != 0);
        end
    end

    // Digit scan and segment pattern selection.
    always_comb begin
        idx_d     = idx_q;
        digit_sel = digits_q[{idx_q, 2'b00} +: 4];
        an_d      = ~(6'(1) << idx_q);
        if (&presc_q) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        if (i_dst == DST_EARLY) begin
            seg_d = SEG_DASH;
        end else if (dval_q == NO_SCORE) begin
            seg_d = SEG_DASH;
        end else if (i_dst == DST_WAIT || i_dst == DST_LIT) begin
            seg_d = SEG_BLANK;
        end else if (blank_v[idx_q]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(digit_sel);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            best_q     <= NO_SCORE;
            last_q     <= NO_SCORE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            src_q      <= NO_SCORE;
            digits_q   <= '0;
            dval_q     <= NO_SCORE;
            prev_dst_q <= 3'b000;
            prev_sb_q  <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= 6'b111110;
            seg_q      <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            best_q     <= best_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            src_q      <= src_d;
            digits_q   <= digits_d;
            dval_q     <= dval_d;
            prev_dst_q <= i_dst;
            prev_sb_q  <= i_show_best;
            presc_q    <= presc_q + SCAN_W'(1);
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign o_seg  = seg_q;
    assign o_an   = an_q;
    assign o_best = best_q;
    assign o_busy = busy_q;

endmodule
